gol_step_scheduler: RTL and testbench

//  Sequences Game-of-Life generations: owns run/pause state, a programmable generation

---
 rtl/gol_step_scheduler_pkg.sv | 21 ++
 rtl/gol_step_scheduler_if.sv | 22 ++
 rtl/gol_step_scheduler_gen_timer.sv | 32 +++
 rtl/gol_step_scheduler.sv | 97 +++++++++
 tb/tb_gol_step_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gol_step_scheduler_pkg.sv
// Shared types and sizing for the Game-of-Life generation scheduler.
`ifndef GRID_SIZE
`define GRID_SIZE 16
`endif

package gol_step_scheduler_pkg;

  localparam int unsigned GRID_SIZE = `GRID_SIZE;
  localparam int unsigned ROW_W     = $clog2(GRID_SIZE);
  localparam int unsigned DIV_W     = 24;
  localparam int unsigned GEN_W     = 16;

  typedef logic [ROW_W-1:0] row_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    COMMIT
  } sched_state_t;

endpackage

// File: rtl/gol_step_scheduler_if.sv
// Row handshake to the next-state engine plus the editor grant handshake.
interface gol_step_scheduler_if;
  import gol_step_scheduler_pkg::*;

  logic     row_valid;
  row_idx_t row_idx;
  logic     row_ready;
  logic     commit;
  logic     edit_req;
  logic     edit_ack;

  modport master (
    output row_valid, row_idx, commit, edit_ack,
    input  row_ready, edit_req
  );

  modport slave (
    input  row_valid, row_idx, commit, edit_ack,
    output row_ready, edit_req
  );

endinterface

// File: rtl/gol_step_scheduler_gen_timer.sv
// Run-mode generation timer: counts up, flags a due tick, holds until the tick is consumed.
module gol_step_scheduler_gen_timer
  import gol_step_scheduler_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] period,
  input  logic             consume,
  output logic             tick_due
);

  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] limit;

  // A period of zero behaves like one: tick due immediately.
  always_comb begin
    limit    = (period == '0) ? '0 : period - DIV_W'(1);
    tick_due = (count >= limit);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!enable || consume) begin
      count <= '0;
    end else if (!tick_due) begin
      count <= count + DIV_W'(1);
    end
  end

endmodule

// File: rtl/gol_step_scheduler.sv
// Generation sequencer: run/pause, timed or single-step starts, row-serial engine drive,
// commit pulse and editor arbitration.
module gol_step_scheduler
  import gol_step_scheduler_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run_toggle,
  input  logic                 step,
  input  logic [DIV_W-1:0]     period,
  gol_step_scheduler_if.master sched_bus,
  output logic                 paused,
  output logic                 busy,
  output logic [GEN_W-1:0]     gen_count
);

  sched_state_t state;
  logic         step_pending;
  logic         tick_due;
  logic         idle;
  logic         start_run;
  logic         start_step;
  logic         grant;
  logic         last_xfer;

  gol_step_scheduler_gen_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .enable   (!paused),
    .period   (period),
    .consume  (start_run),
    .tick_due (tick_due)
  );

  // A toggle in flight blocks starts and grants so the pause decision settles first.
  always_comb begin
    idle       = (state == IDLE);
    start_run  = idle && !paused && tick_due && !run_toggle;
    start_step = idle && paused && step_pending && !sched_bus.edit_req
                 && !sched_bus.edit_ack && !run_toggle;
    grant      = idle && paused && sched_bus.edit_req && !sched_bus.edit_ack && !run_toggle;
    last_xfer  = sched_bus.row_valid && sched_bus.row_ready
                 && (sched_bus.row_idx == row_idx_t'(GRID_SIZE - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      paused             <= 1'b1;
      step_pending       <= 1'b0;
      busy               <= 1'b0;
      gen_count          <= '0;
      sched_bus.row_valid <= 1'b0;
      sched_bus.row_idx   <= '0;
      sched_bus.commit    <= 1'b0;
      sched_bus.edit_ack  <= 1'b0;
    end else begin
      paused             <= paused ^ run_toggle;
      sched_bus.edit_ack <= grant;
      sched_bus.commit   <= 1'b0;

      if (run_toggle && paused) begin
        step_pending <= 1'b0;
      end else begin
        step_pending <= (step_pending && !start_step) || (step && paused);
      end

      case (state)
        IDLE: begin
          if (start_run || start_step) begin
            state               <= COMPUTE;
            busy                <= 1'b1;
            sched_bus.row_valid <= 1'b1;
            sched_bus.row_idx   <= '0;
          end
        end
        COMPUTE: begin
          if (last_xfer) begin
            state               <= COMMIT;
            sched_bus.row_valid <= 1'b0;
            sched_bus.row_idx   <= '0;
            sched_bus.commit    <= 1'b1;
          end else if (sched_bus.row_valid && sched_bus.row_ready) begin
            sched_bus.row_idx <= sched_bus.row_idx + ROW_W'(1);
          end
        end
        COMMIT: begin
          state     <= IDLE;
          busy      <= 1'b0;
          gen_count <= gen_count + GEN_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gol_step_scheduler.sv
// Self-checking bench for gol_step_scheduler: directed scenarios plus randomized traffic
// compared cycle by cycle against a generation-phase reference model.
module tb_gol_step_scheduler;
  import gol_step_scheduler_pkg::*;

  localparam int G = int'(GRID_SIZE);

  logic             clk = 1'b0;
  logic             reset;
  logic             run_toggle;
  logic             step;
  logic [DIV_W-1:0] period;
  logic             paused;
  logic             busy;
  logic [GEN_W-1:0] gen_count;

  gol_step_scheduler_if bus ();

  gol_step_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .run_toggle (run_toggle),
    .step       (step),
    .period     (period),
    .sched_bus  (bus),
    .paused     (paused),
    .busy       (busy),
    .gen_count  (gen_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: phase -1 = idle, 0..G-1 = row on offer, G = commit cycle.
  bit m_paused;
  bit m_pending;
  bit m_ack;
  int m_phase;
  int m_cnt;
  int m_gen;

  task automatic model_reset();
    m_paused  = 1'b1;
    m_pending = 1'b0;
    m_ack     = 1'b0;
    m_phase   = -1;
    m_cnt     = 0;
    m_gen     = 0;
  endtask

  task automatic model_update();
    int lim;
    bit idle, due, srun, sstep, grant;
    lim   = (period == 0) ? 0 : int'(period) - 1;
    idle  = (m_phase < 0);
    due   = (m_cnt >= lim);
    srun  = idle && !m_paused && due && !run_toggle;
    grant = idle && m_paused && bus.edit_req && !m_ack && !run_toggle;
    sstep = idle && m_paused && m_pending && !bus.edit_req && !m_ack && !run_toggle;
    if (m_paused || srun) m_cnt = 0;
    else if (!due)        m_cnt++;
    if (run_toggle && m_paused) m_pending = 1'b0;
    else m_pending = (m_pending && !sstep) || (step && m_paused);
    if (srun || sstep) m_phase = 0;
    else if (m_phase == G) begin
      m_phase = -1;
      m_gen++;
    end else if (m_phase >= 0 && bus.row_ready) m_phase++;
    m_ack    = grant;
    m_paused = m_paused ^ run_toggle;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset) model_reset();
    else       model_update();
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    int commits = 0;
    reset = 1'b1; run_toggle = 1'b0; step = 1'b0; period = DIV_W'(5);
    bus.row_ready = 1'b1; bus.edit_req = 1'b0;
    model_reset();
    repeat (3) cycle();
    reset = 1'b0;
    repeat (20) begin
      cycle();
      if (bus.commit) commits++;
    end
    n_cmp++; if (paused !== 1'b1) begin n_err++; $display("FAIL reset_paused: got %0b want 1", paused); end
    n_cmp++; if (bus.row_valid !== 1'b0) begin n_err++; $display("FAIL reset_row_valid: got %0b want 0", bus.row_valid); end
    n_cmp++; if (commits != 0) begin n_err++; $display("FAIL reset_commit: got %0d commits want 0", commits); end
    n_cmp++; if (gen_count !== '0) begin n_err++; $display("FAIL reset_gen_count: got %0d want 0", gen_count); end
    n_cmp++; if ({busy, bus.edit_ack, bus.row_idx} !== '0) begin n_err++;
      $display("FAIL reset_misc: busy=%0b ack=%0b idx=%0d want all 0", busy, bus.edit_ack, bus.row_idx); end
  endtask

  task automatic test_single_step();
    int rows[$];
    int k0, first = -1, last = -1, ccyc = -1, commits = 0;
    bit seq_ok = 1'b1;
    k0 = cyc;
    step = 1'b1; cycle(); step = 1'b0;
    repeat (40) begin
      cycle();
      if (bus.row_valid) begin
        rows.push_back(int'(bus.row_idx));
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (bus.commit) begin commits++; ccyc = cyc; end
    end
    foreach (rows[i]) if (rows[i] != i) seq_ok = 1'b0;
    n_cmp++; if (rows.size() != G || !seq_ok) begin n_err++;
      $display("FAIL step_rows: got %0d rows (in order=%0b) want %0d in order", rows.size(), seq_ok, G); end
    n_cmp++; if (first != k0 + 2) begin n_err++; $display("FAIL step_latency: first row cycle %0d want %0d", first, k0 + 2); end
    n_cmp++; if (last - first != G - 1) begin n_err++; $display("FAIL step_consecutive: span %0d want %0d", last - first, G - 1); end
    n_cmp++; if (commits != 1 || ccyc != last + 1) begin n_err++;
      $display("FAIL step_commit: %0d commits at %0d want 1 at %0d", commits, ccyc, last + 1); end
    n_cmp++; if (gen_count !== GEN_W'(1)) begin n_err++; $display("FAIL step_gen_count: got %0d want 1", gen_count); end
  endtask

  task automatic test_run();
    int starts[$];
    int g0, commits = 0, late_commits = 0, late_starts = 0;
    bit prev_v, found = 1'b0;
    g0 = m_gen;
    period = DIV_W'(5);
    run_toggle = 1'b1; cycle(); run_toggle = 1'b0;
    prev_v = bus.row_valid;
    repeat (100) begin
      cycle();
      if (bus.row_valid && bus.row_idx == '0 && !prev_v) starts.push_back(cyc);
      if (bus.commit) commits++;
      prev_v = bus.row_valid;
    end
    for (int i = 1; i < starts.size(); i++) begin
      n_cmp++; if (starts[i] - starts[i-1] != 18) begin n_err++;
        $display("FAIL run_p5_spacing: got %0d want 18", starts[i] - starts[i-1]); end
    end
    n_cmp++; if (starts.size() < 4) begin n_err++; $display("FAIL run_p5_count: got %0d starts want >=4", starts.size()); end
    starts.delete();
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (bus.commit) commits++;
      if (bus.row_valid && bus.row_idx == '0 && !prev_v) begin found = 1'b1; starts.push_back(cyc); end
      prev_v = bus.row_valid;
    end
    period = DIV_W'(40);
    repeat (130) begin
      cycle();
      if (bus.row_valid && bus.row_idx == '0 && !prev_v) starts.push_back(cyc);
      if (bus.commit) commits++;
      prev_v = bus.row_valid;
    end
    for (int i = 1; i < starts.size(); i++) begin
      n_cmp++; if (starts[i] - starts[i-1] != 40) begin n_err++;
        $display("FAIL run_p40_spacing: got %0d want 40", starts[i] - starts[i-1]); end
    end
    n_cmp++; if (starts.size() != 4) begin n_err++; $display("FAIL run_p40_count: got %0d starts want 4", starts.size()); end
    // Pause while a generation is in flight: it must still commit, then stay quiet.
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      cycle();
      if (bus.commit) commits++;
      found = bus.row_valid && bus.row_idx == row_idx_t'(2);
    end
    run_toggle = 1'b1; cycle(); run_toggle = 1'b0;
    prev_v = bus.row_valid;
    repeat (80) begin
      cycle();
      if (bus.commit) late_commits++;
      if (bus.row_valid && !prev_v) late_starts++;
      prev_v = bus.row_valid;
    end
    commits += late_commits;
    n_cmp++; if (!found || late_commits != 1 || late_starts != 0 || paused !== 1'b1) begin n_err++;
      $display("FAIL run_pause_midgen: found=%0b commits=%0d starts=%0d paused=%0b want 1,1,0,1",
               found, late_commits, late_starts, paused); end
    n_cmp++; if (gen_count !== GEN_W'(g0 + commits)) begin n_err++;
      $display("FAIL run_gen_count: got %0d want %0d", gen_count, GEN_W'(g0 + commits)); end
  endtask

  task automatic test_stall();
    int xfers[$];
    int first = -1, ccyc = -1, stall_cnt = 0, hold3 = 0;
    bit done_stall = 1'b0, seq_ok = 1'b1;
    step = 1'b1; cycle(); step = 1'b0;
    repeat (60) begin
      cycle();
      if (bus.commit) ccyc = cyc;
      if (bus.row_valid && first < 0) first = cyc;
      if (bus.row_valid && bus.row_idx == row_idx_t'(3)) begin
        hold3++;
        if (!done_stall) begin done_stall = 1'b1; stall_cnt = 7; end
      end
      bus.row_ready = (stall_cnt == 0);
      if (stall_cnt > 0) stall_cnt--;
      if (bus.row_valid && bus.row_ready) xfers.push_back(int'(bus.row_idx));
    end
    bus.row_ready = 1'b1;
    foreach (xfers[i]) if (xfers[i] != i) seq_ok = 1'b0;
    n_cmp++; if (xfers.size() != G || !seq_ok) begin n_err++;
      $display("FAIL stall_rows: got %0d transfers (in order=%0b) want %0d", xfers.size(), seq_ok, G); end
    n_cmp++; if (hold3 != 8) begin n_err++; $display("FAIL stall_hold: row 3 offered %0d cycles want 8", hold3); end
    n_cmp++; if (ccyc - first != G + 7) begin n_err++;
      $display("FAIL stall_commit_delay: got %0d want %0d", ccyc - first, G + 7); end
  endtask

  task automatic test_edit();
    int ccyc = -1, acyc = -1;
    bit busy_at_ack = 1'b1;
    bus.edit_req = 1'b1; step = 1'b1; cycle(); step = 1'b0;
    n_cmp++; if (bus.edit_ack !== 1'b1 || bus.row_valid !== 1'b0) begin n_err++;
      $display("FAIL edit_ack_first: ack=%0b valid=%0b want 1,0", bus.edit_ack, bus.row_valid); end
    bus.edit_req = 1'b0;
    cycle();
    n_cmp++; if (bus.edit_ack !== 1'b0 || bus.row_valid !== 1'b0) begin n_err++;
      $display("FAIL edit_gap: ack=%0b valid=%0b want 0,0", bus.edit_ack, bus.row_valid); end
    cycle();
    n_cmp++; if (bus.row_valid !== 1'b1 || bus.row_idx !== '0) begin n_err++;
      $display("FAIL edit_step_start: valid=%0b idx=%0d want 1,0", bus.row_valid, bus.row_idx); end
    bus.edit_req = 1'b1;
    for (int i = 0; i < 40 && acyc < 0; i++) begin
      cycle();
      if (bus.commit) ccyc = cyc;
      if (bus.edit_ack) begin acyc = cyc; busy_at_ack = busy; bus.edit_req = 1'b0; end
    end
    bus.edit_req = 1'b0;
    n_cmp++; if (ccyc < 0 || acyc != ccyc + 2 || busy_at_ack) begin n_err++;
      $display("FAIL edit_during_compute: ack at %0d commit at %0d busy=%0b want ack=commit+2 busy=0",
               acyc, ccyc, busy_at_ack); end
    repeat (3) cycle();
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    int commits = 0;
    step = 1'b1; cycle(); step = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle();
      found = bus.row_valid && bus.row_idx == row_idx_t'(9);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (!found || {bus.row_valid, bus.row_idx, bus.commit, busy, bus.edit_ack, gen_count} !== '0
                 || paused !== 1'b1) begin n_err++;
      $display("FAIL reset_mid_async: found=%0b valid=%0b idx=%0d commit=%0b busy=%0b gen=%0d paused=%0b",
               found, bus.row_valid, bus.row_idx, bus.commit, busy, gen_count, paused); end
    model_reset();
    cycle();
    reset = 1'b0;
    repeat (30) begin
      cycle();
      if (bus.commit) commits++;
    end
    n_cmp++; if (commits != 0 || gen_count !== '0) begin n_err++;
      $display("FAIL reset_mid_abort: commits=%0d gen=%0d want 0,0", commits, gen_count); end
  endtask

  task automatic test_random();
    logic [ROW_W+GEN_W+4:0] got, exp;
    bit v;
    for (int i = 0; i < 3000; i++) begin
      run_toggle    = ($urandom_range(0, 59) == 0);
      step          = ($urandom_range(0, 7) == 0);
      bus.row_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) period = DIV_W'($urandom_range(0, 30));
      cycle();
      v   = (m_phase >= 0 && m_phase < G);
      exp = {v, row_idx_t'(v ? m_phase : 0), (m_phase == G), (m_phase >= 0), m_paused, m_ack, GEN_W'(m_gen)};
      got = {bus.row_valid, bus.row_idx, bus.commit, busy, paused, bus.edit_ack, gen_count};
      n_cmp++; if (got !== exp) begin n_err++;
        $display("FAIL random_cycle_%0d: got %h want %h (valid,idx,commit,busy,paused,ack,gen)", cyc, got, exp); end
      if (bus.edit_req && m_ack) bus.edit_req = 1'b0;
      else if (!bus.edit_req && $urandom_range(0, 9) == 0) bus.edit_req = 1'b1;
    end
    run_toggle = 1'b0; step = 1'b0; bus.edit_req = 1'b0; bus.row_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_run();
    test_stall();
    test_edit();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
